// File: rtl/axi_accel_cfg_slave.sv
// axi_accel_cfg_slave: AXI4 responder that terminates single-beat accesses to the
// accelerator config bank (ID, STATUS, ADDR, WDATA, CTRL) and drives start/busy/done.
module axi_accel_cfg_slave #(
  parameter int unsigned AXI_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [63:0] ID_VALUE       = 64'h5354_524C_0000_0001
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [2:0]                aw_size_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] w_data_i,
  input  logic [7:0]                w_strb_i,
  input  logic                      w_last_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]                b_resp_o,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]                ar_len_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]   r_id_o,
  output logic [AXI_DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic [63:0]               acc_addr_o,
  output logic [63:0]               acc_wdata_o,
  output logic                      acc_start_o,
  input  logic                      acc_done_i
);

  if (AXI_DATA_WIDTH != 64) begin : gen_width_check
    $error("axi_accel_cfg_slave: AXI_DATA_WIDTH must be 64");
  end

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t                 wstate_reg, wstate_next;
  rstate_t                 rstate_reg, rstate_next;

  logic [AXI_ID_WIDTH-1:0] wid_reg;
  logic [2:0]              widx_reg;
  logic [7:0]              wlen_reg;
  logic [1:0]              bresp_reg;

  logic [AXI_ID_WIDTH-1:0] rid_reg;
  logic [7:0]              rlen_reg;
  logic [7:0]              rcnt_reg;
  logic [63:0]             rdata_reg;
  logic [1:0]              rresp_reg;

  logic [63:0]             addr_reg, addr_next;
  logic [63:0]             wdata_reg, wdata_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    start_reg;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic commit, wr_status, wr_addr, wr_wdata, wr_ctrl;
  logic start_req, do_start, done_clr, beat_err;
  logic [63:0] rd_snap;
  logic        rd_err;

  // Only addr[5:3] selects a register; size is implied by the fixed 64-bit bus.
  logic unused_inputs;
  assign unused_inputs = ^{aw_size_i, aw_addr_i[AXI_ADDR_WIDTH-1:6], aw_addr_i[2:0],
                           ar_addr_i[AXI_ADDR_WIDTH-1:6], ar_addr_i[2:0]};

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i & w_ready_o;
  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o & r_ready_i;

  // ---------------- write channel ----------------
  always_comb begin
    wstate_next = wstate_reg;
    aw_ready_o  = 1'b0;
    w_ready_o   = 1'b0;
    b_valid_o   = 1'b0;
    case (wstate_reg)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) wstate_next = W_DATA;
      end
      W_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) wstate_next = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) wstate_next = W_IDLE;
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  // Bursts are drained beat by beat but never committed.
  assign commit    = w_hs && (wlen_reg == 8'd0);
  assign wr_status = commit && (widx_reg == 3'd1);
  assign wr_addr   = commit && (widx_reg == 3'd2);
  assign wr_wdata  = commit && (widx_reg == 3'd4);
  assign wr_ctrl   = commit && (widx_reg == 3'd5);
  assign start_req = wr_ctrl && w_strb_i[0] && w_data_i[0];
  assign do_start  = start_req && !busy_reg;
  assign done_clr  = wr_status && w_strb_i[0] && w_data_i[1];
  assign beat_err  = (wlen_reg != 8'd0) || (widx_reg[2:1] == 2'b11) || (start_req && busy_reg);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wstate_reg <= W_IDLE;
      wid_reg    <= '0;
      widx_reg   <= '0;
      wlen_reg   <= '0;
      bresp_reg  <= RESP_OKAY;
    end else begin
      wstate_reg <= wstate_next;
      if (aw_hs) begin
        wid_reg   <= aw_id_i;
        widx_reg  <= aw_addr_i[5:3];
        wlen_reg  <= aw_len_i;
        bresp_reg <= RESP_OKAY;
      end else if (w_hs && beat_err) begin
        bresp_reg <= RESP_SLVERR;
      end
    end
  end

  assign b_id_o   = wid_reg;
  assign b_resp_o = bresp_reg;

  // ---------------- register bank ----------------
  for (genvar gi = 0; gi < 8; gi++) begin : gen_lane
    assign addr_next[gi*8 +: 8]  = (wr_addr && w_strb_i[gi])  ? w_data_i[gi*8 +: 8] : addr_reg[gi*8 +: 8];
    assign wdata_next[gi*8 +: 8] = (wr_wdata && w_strb_i[gi]) ? w_data_i[gi*8 +: 8] : wdata_reg[gi*8 +: 8];
  end

  // A completion landing on the same edge as a W1C keeps done set.
  assign busy_next = do_start || (busy_reg && !acc_done_i);
  assign done_next = acc_done_i || (done_reg && !done_clr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      start_reg <= do_start;
    end
  end

  assign acc_addr_o  = addr_reg;
  assign acc_wdata_o = wdata_reg;
  assign acc_start_o = start_reg;

  // ---------------- read channel ----------------
  always_comb begin
    rd_snap = '0;
    rd_err  = 1'b0;
    case (ar_addr_i[5:3])
      3'd0:       rd_snap = ID_VALUE;
      3'd1:       rd_snap = {62'd0, done_reg, busy_reg};
      3'd2:       rd_snap = addr_reg;
      3'd4:       rd_snap = wdata_reg;
      3'd6, 3'd7: rd_err  = 1'b1;
      default:    rd_snap = '0;
    endcase
    if (ar_len_i != 8'd0) begin
      rd_snap = '0;
      rd_err  = 1'b1;
    end
  end

  always_comb begin
    rstate_next = rstate_reg;
    ar_ready_o  = 1'b0;
    r_valid_o   = 1'b0;
    case (rstate_reg)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) rstate_next = R_DATA;
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        if (r_ready_i && r_last_o) rstate_next = R_IDLE;
      end
      default: rstate_next = R_IDLE;
    endcase
  end

  // Data is captured at the AR handshake, so a same-edge write is not observed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rstate_reg <= R_IDLE;
      rid_reg    <= '0;
      rlen_reg   <= '0;
      rcnt_reg   <= '0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else begin
      rstate_reg <= rstate_next;
      if (ar_hs) begin
        rid_reg   <= ar_id_i;
        rlen_reg  <= ar_len_i;
        rcnt_reg  <= 8'd0;
        rdata_reg <= rd_snap;
        rresp_reg <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs && !r_last_o) begin
        rcnt_reg <= rcnt_reg + 8'd1;
      end
    end
  end

  assign r_last_o = (rstate_reg == R_DATA) && (rcnt_reg == rlen_reg);
  assign r_id_o   = rid_reg;
  assign r_data_o = rdata_reg;
  assign r_resp_o = rresp_reg;

endmodule

// File: tb/tb_axi_accel_cfg_slave.sv
// tb_axi_accel_cfg_slave: directed and randomized accesses to axi_accel_cfg_slave,
// checked against a register-level model of the config bank.
module tb_axi_accel_cfg_slave;

  localparam logic [63:0] ID_VALUE = 64'h5354_524C_0000_0001;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [4:0]  aw_id, b_id, ar_id, r_id;
  logic [63:0] aw_addr, ar_addr, w_data, r_data, acc_addr, acc_wdata;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size;
  logic [1:0]  b_resp, r_resp;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic        acc_start, acc_done;

  int checks = 0;
  int failures = 0;

  // Reference model of the architectural register state
  logic [63:0] m_addr, m_wdata;
  logic        m_busy, m_done;

  always #5 clk = ~clk;

  axi_accel_cfg_slave dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_size_i(aw_size),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp),
    .r_last_o(r_last),
    .acc_addr_o(acc_addr), .acc_wdata_o(acc_wdata), .acc_start_o(acc_start), .acc_done_i(acc_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return ID_VALUE;
      3'd1:    return {62'd0, m_done, m_busy};
      3'd2:    return m_addr;
      3'd4:    return m_wdata;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic pulse_done();
    acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    m_done = 1'b1;
    m_busy = 1'b0;
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input logic [7:0] len, input int hold, input bit done_at_w, input string tag);
    logic [2:0] idx;
    logic [1:0] exp_resp;
    logic       exp_start;
    logic [4:0] id;
    int         cyc;
    idx = addr[5:3];
    id  = 5'($urandom);
    exp_resp  = OKAY;
    exp_start = 1'b0;
    if (len != 0 || idx >= 3'd6) exp_resp = SLVERR;
    else if (idx == 3'd5 && strb[0] && data[0]) begin
      if (m_busy) exp_resp = SLVERR;
      else exp_start = 1'b1;
    end
    aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd3;
    cyc = 0;
    while (!aw_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check({tag, "_aw_ready"}, aw_ready, 1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    for (int bt = 0; bt <= int'(len); bt++) begin
      check({tag, "_w_ready"}, w_ready, 1);
      check({tag, "_b_early"}, b_valid, 0);
      w_valid = 1'b1; w_data = data; w_strb = strb; w_last = (bt == int'(len));
      if (bt == int'(len) && done_at_w) acc_done = 1'b1;
      @(posedge clk); #1;
      w_valid = 1'b0; w_last = 1'b0; acc_done = 1'b0;
    end
    if (len == 0) begin
      for (int k = 0; k < 8; k++) begin
        if (idx == 3'd2 && strb[k]) m_addr[k*8 +: 8]  = data[k*8 +: 8];
        if (idx == 3'd4 && strb[k]) m_wdata[k*8 +: 8] = data[k*8 +: 8];
      end
      if (idx == 3'd1 && strb[0] && data[1]) m_done = 1'b0;
    end
    if (exp_start) m_busy = 1'b1;
    if (done_at_w) begin
      m_done = 1'b1;
      if (!exp_start) m_busy = 1'b0;
    end
    check({tag, "_b_valid"}, b_valid, 1);
    check({tag, "_b_id"}, b_id, id);
    check({tag, "_b_resp"}, b_resp, exp_resp);
    check({tag, "_start"}, acc_start, exp_start);
    check({tag, "_acc_addr"}, acc_addr, m_addr);
    check({tag, "_acc_wdata"}, acc_wdata, m_wdata);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_b_hold_valid"}, b_valid, 1);
      check({tag, "_b_hold_id"}, b_id, id);
      check({tag, "_b_hold_resp"}, b_resp, exp_resp);
    end
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    check({tag, "_b_done"}, b_valid, 0);
    check({tag, "_start_off"}, acc_start, 0);
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input int hold, input string tag);
    logic [2:0]  idx;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
    logic [4:0]  id;
    int          cyc;
    idx      = addr[5:3];
    id       = 5'($urandom);
    exp_data = model_read(idx);
    exp_resp = (idx >= 3'd6) ? SLVERR : OKAY;
    if (len != 0) begin exp_data = '0; exp_resp = SLVERR; end
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
    cyc = 0;
    while (!ar_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check({tag, "_ar_ready"}, ar_ready, 1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    for (int bt = 0; bt <= int'(len); bt++) begin
      for (int h = 0; h <= hold; h++) begin
        if (h > 0) begin @(posedge clk); #1; end
        check({tag, "_r_valid"}, r_valid, 1);
        check({tag, "_r_data"}, r_data, exp_data);
        check({tag, "_r_resp"}, r_resp, exp_resp);
        check({tag, "_r_last"}, r_last, (bt == int'(len)));
        check({tag, "_r_id"}, r_id, id);
      end
      r_ready = 1'b1;
      @(posedge clk); #1;
      r_ready = 1'b0;
    end
    check({tag, "_r_done"}, r_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rnd_addr, rnd_data, old_wdata, new_wdata;
    logic [7:0]  rnd_len, rnd_strb;
    int          op;

    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; r_ready = 0; acc_done = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_aw_ready", aw_ready, 1);
    check("rst_ar_ready", ar_ready, 1);
    check("rst_w_ready", w_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_start", acc_start, 0);
    check("rst_acc_addr", acc_addr, 0);
    check("rst_acc_wdata", acc_wdata, 0);
    check("rst_r_data", r_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: partial-strobe write to ADDR
    axi_write(64'h5000_0010, 64'h9000_0004, 8'h0F, 8'd0, 0, 1'b0, "t1_wr");
    check("t1_addr_value", acc_addr, 64'h0000_0000_9000_0004);
    axi_read(64'h5000_0010, 8'd0, 0, "t1_rd");
    axi_read(64'h0000_0000, 8'd0, 0, "t1_id");

    // T2: start/busy/done handshake with W1C
    axi_write(64'h20, 64'h2424_4242, 8'hFF, 8'd0, 0, 1'b0, "t2_wdata");
    axi_write(64'h28, 64'h1, 8'h01, 8'd0, 0, 1'b0, "t2_start");
    axi_read(64'h08, 8'd0, 0, "t2_busy");
    check("t2_status_model", model_read(3'd1), 64'h1);

    // T3: start while busy is rejected
    axi_write(64'h28, 64'h1, 8'h01, 8'd0, 0, 1'b0, "t3_busy_start");
    axi_read(64'h08, 8'd0, 0, "t3_status");

    pulse_done();
    axi_read(64'h08, 8'd0, 0, "t2_done");
    axi_write(64'h08, 64'h2, 8'h01, 8'd0, 0, 1'b0, "t2_w1c");
    axi_read(64'h08, 8'd0, 0, "t2_cleared");

    // done set and W1C on the same edge, done arriving while idle
    axi_write(64'h08, 64'h2, 8'h01, 8'd0, 0, 1'b1, "set_wins");
    axi_read(64'h08, 8'd0, 0, "set_wins_rd");
    axi_write(64'h08, 64'h2, 8'h01, 8'd0, 0, 1'b0, "set_wins_clr");

    // T4: error decode and bursts
    axi_write(64'h30, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'd0, 0, 1'b0, "t4_idx6");
    axi_write(64'h10, 64'h1234_5678_9ABC_DEF0, 8'hFF, 8'd3, 0, 1'b0, "t4_burst");
    axi_read(64'h10, 8'd0, 0, "t4_addr_kept");
    axi_write(64'h18, 64'hAAAA, 8'hFF, 8'd0, 0, 1'b0, "t4_rsvd");
    axi_read(64'h38, 8'd0, 0, "t4_rd_idx7");

    // T5: read burst and back-pressure
    axi_read(64'h20, 8'd1, 5, "t5_rd_burst");
    axi_write(64'h20, 64'h0102_0304_0506_0708, 8'hF0, 8'd0, 5, 1'b0, "t5_wr_hold");
    axi_read(64'h20, 8'd0, 5, "t5_rd_hold");

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      op       = int'($urandom_range(0, 9));
      rnd_addr = {$urandom, $urandom};
      rnd_data = {$urandom, $urandom};
      rnd_strb = 8'($urandom);
      rnd_len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
      if (op < 5)      axi_write(rnd_addr, rnd_data, rnd_strb, rnd_len, int'($urandom_range(0, 2)), 1'b0, "rnd_wr");
      else if (op < 9) axi_read(rnd_addr, rnd_len, int'($urandom_range(0, 2)), "rnd_rd");
      else             pulse_done();
    end

    // T6: read racing a write commit, then reset with both responses pending
    old_wdata = m_wdata;
    new_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    aw_valid = 1'b1; aw_addr = 64'h20; aw_len = 8'd0; aw_id = 5'h11; aw_size = 3'd3;
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_valid = 1'b1; w_data = new_wdata; w_strb = 8'hFF; w_last = 1'b1;
    ar_valid = 1'b1; ar_addr = 64'h20; ar_len = 8'd0; ar_id = 5'h0A;
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0; ar_valid = 1'b0;
    check("t6_b_valid", b_valid, 1);
    check("t6_r_valid", r_valid, 1);
    check("t6_r_pre_write", r_data, old_wdata);
    check("t6_wdata_new", acc_wdata, new_wdata);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_b_valid", b_valid, 0);
    check("t6_rst_r_valid", r_valid, 0);
    check("t6_rst_wdata", acc_wdata, 0);
    check("t6_rst_addr", acc_addr, 0);
    check("t6_rst_aw_ready", aw_ready, 1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(64'h20, 8'd0, 0, "t6_rd_cleared");
    axi_write(64'h10, 64'h0000_00C0_FFEE_0000, 8'hFF, 8'd0, 0, 1'b0, "t6_wr_after");
    axi_read(64'h10, 8'd0, 0, "t6_rd_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
